button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of independent button channels.
REQ-002 SHALL have parameter DB_CYCLES, default 50000, consecutive cycles a new level must persist (2 ms at 25 MHz), legal range 1..65535.
REQ-003 SHALL have parameter REPEAT_DELAY, default 12500000, cycles from press to first auto-repeat, legal range 1..2^24-1.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 2500000, cycles between subsequent auto-repeats, legal range 1..2^24-1.
REQ-005 SHALL have parameter REPEAT_MASK, default 4'b1100, channels eligible for auto-repeat (up/down keys).
REQ-006 SHALL have port clk, input, 1, single clock for all logic.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port btn_raw, input, N_BTN, asynchronous raw pin levels, 1 = pressed.
REQ-009 SHALL have port btn_n, output, N_BTN, registered debounced level, active-low (0 = pressed), drop-in for pause_n/new_game_n/down_key_n/up_key_n.
REQ-010 SHALL have port btn_press, output, N_BTN, registered one-cycle press pulse per channel.

Function
REQ-011 Each channel SHALL pass btn_raw through a two-flop synchronizer; output s is the second flop.
REQ-012 Each channel SHALL keep a 16-bit debounce counter: s equal to debounced state -> counter cleared; s differs and counter = DB_CYCLES-1 -> state takes s, counter cleared; otherwise counter increments.
REQ-013 Latency: raw level held stable from sampling edge 1 SHALL change btn_n on edge DB_CYCLES+2; any excursion shorter than DB_CYCLES cycles at s SHALL leave btn_n unchanged and clear the counter.
REQ-014 btn_press SHALL pulse high for exactly one cycle on the same edge btn_n goes 1->0; no pulse on release.
REQ-015 Each channel SHALL run a repeat FSM with states IDLE, DELAY, REPEAT and a 24-bit timer.
REQ-016 IDLE -> DELAY on debounced press (timer cleared); DELAY -> REPEAT when timer reaches REPEAT_DELAY-1, emitting one btn_press pulse; REPEAT re-pulses every REPEAT_PERIOD cycles, timer cleared on each pulse.
REQ-017 Debounced release SHALL force the FSM to IDLE from any state on that edge with no pulse; release wins over a coincident repeat expiry.
REQ-018 Channels SHALL be fully independent; simultaneous pulses on several channels in one cycle are legal.
REQ-019 Channels with REPEAT_MASK bit 0 SHALL stay in IDLE and produce only the initial press pulse.

Reset
REQ-020 While rst_n = 0 at a clk edge: synchronizer flops 0, debounced state released, btn_n = all ones, btn_press = 0, all counters 0, FSMs IDLE.
REQ-021 Reset asserted mid-debounce or mid-repeat SHALL abandon the operation with no pulse; a button held through reset release SHALL register as a fresh press DB_CYCLES+2 edges later, with a btn_press pulse.

Configuration
REQ-022 Macro BTN_AUTOREPEAT_EN defined: REQ-015..REQ-017 and REQ-019 behaviour compiled in.
REQ-023 Macro BTN_AUTOREPEAT_EN undefined: repeat FSMs and timers SHALL be absent; every channel emits only the initial press pulse; REPEAT_DELAY, REPEAT_PERIOD and REPEAT_MASK ignored; all other behaviour identical.

Verification (DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, macro defined unless noted)
REQ-024 Reset, btn_raw=0 for 10 cycles -> btn_n=4'b1111, btn_press=0 throughout.
REQ-025 btn_raw[0] 0->1 sampled at edge 1, held -> btn_n[0]=0 and btn_press[0]=1 after edge 6, btn_press[0]=0 after edge 7, no further pulses (bit 0 not in mask).
REQ-026 btn_raw[1] high for 3 cycles then low, repeated 5 times -> btn_n[1] stays 1, btn_press[1] never pulses.
REQ-027 btn_raw[3] held 60 cycles -> pulses at press edge, +20, +28, +36, +44, +52 edges; release -> no pulse and btn_n[3]=1 after DB_CYCLES+2 edges.
REQ-028 btn_raw[2] and btn_raw[3] rise on the same edge -> both btn_press bits pulse on the same cycle; reset asserted 10 cycles into DELAY with keys held -> outputs released; after reset release, new press pulses 6 edges later.
REQ-029 Macro undefined, btn_raw[3] held 60 cycles -> exactly one btn_press[3] pulse.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchronizer, debouncer and press-pulse generator with optional auto-repeat.
// Auto-repeat FSMs are compiled in only when BTN_AUTOREPEAT_EN is defined.
module button_conditioner #(
  parameter int N_BTN = 4,
  parameter int DB_CYCLES = 50000,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter logic [N_BTN-1:0] REPEAT_MASK = N_BTN'(4'b1100)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] btn_press
);
  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [23:0] DLY_LAST = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] PER_LAST = 24'(REPEAT_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;
`endif
  logic [N_BTN-1:0] sync1, sync2;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end
  genvar g;
  for (g = 0; g < N_BTN; g++) begin : g_ch
    logic [15:0] cnt;
    logic db_n, press_q, commit, press_ev, rep_pulse;
    // btn_n is the debounced state itself, so the synchronized level "differs" when it equals db_n
    assign commit = (sync2[g] == db_n) && (cnt == DB_LAST);
    assign press_ev = commit & sync2[g];
    assign btn_n[g] = db_n;
    assign btn_press[g] = press_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt <= '0;
        db_n <= 1'b1;
        press_q <= 1'b0;
      end else begin
        cnt <= (sync2[g] != db_n || commit) ? 16'd0 : cnt + 16'd1;
        db_n <= commit ? ~sync2[g] : db_n;
        press_q <= press_ev | rep_pulse;
      end
    end
`ifdef BTN_AUTOREPEAT_EN
    if (REPEAT_MASK[g]) begin : g_rep
      rep_state_t state, state_nx;
      logic [23:0] timer, timer_nx;
      logic release_ev;
      assign release_ev = commit & ~sync2[g];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state <= IDLE;
          timer <= '0;
        end else begin
          state <= state_nx;
          timer <= timer_nx;
        end
      end
      // release is checked first so it wins over a coincident repeat expiry
      always_comb begin
        state_nx = state;
        timer_nx = timer + 24'd1;
        rep_pulse = 1'b0;
        if (release_ev) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else if (press_ev) begin
          state_nx = DELAY;
          timer_nx = '0;
        end else if (state == IDLE) begin
          timer_nx = '0;
        end else if (state == DELAY && timer == DLY_LAST) begin
          state_nx = REPEAT;
          timer_nx = '0;
          rep_pulse = 1'b1;
        end else if (state == REPEAT && timer == PER_LAST) begin
          timer_nx = '0;
          rep_pulse = 1'b1;
        end
      end
    end else begin : g_norep
      assign rep_pulse = 1'b0;
    end
`else
    assign rep_pulse = 1'b0;
`endif
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of debounce latency, glitch rejection, press pulses, auto-repeat and reset.
module tb_button_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] btn_raw = '0;
  logic [3:0] btn_n, btn_press;
  int total = 0, bad = 0, edge_no = 0;
  int pulses[4];
  int pe3[$];
  logic [3:0] n_min;

  button_conditioner #(
    .N_BTN(4), .DB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .REPEAT_MASK(4'b1100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_n(btn_n), .btn_press(btn_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
    n_min = n_min & btn_n;
    for (int c = 0; c < 4; c++) if (btn_press[c]) pulses[c]++;
    if (btn_press[3]) pe3.push_back(edge_no);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_log();
    edge_no = 0;
    n_min = 4'hf;
    pe3.delete();
    for (int c = 0; c < 4; c++) pulses[c] = 0;
  endtask

  initial begin
    int exp_pe[$];
    clear_log();
    steps(3);
    check("rst_btn_n", 32'(btn_n), 32'hf);
    check("rst_press", 32'(btn_press), 32'h0);
    rst_n = 1'b1;
    clear_log();
    steps(10);
    check("idle_btn_n", 32'(n_min), 32'hf);
    check("idle_pulses", 32'(pulses[0] + pulses[1] + pulses[2] + pulses[3]), 32'd0);

    clear_log();
    btn_raw[0] = 1'b1;
    steps(5);
    check("b0_e5_btn_n", 32'(btn_n[0]), 32'd1);
    check("b0_e5_press", 32'(btn_press[0]), 32'd0);
    step();
    check("b0_e6_btn_n", 32'(btn_n[0]), 32'd0);
    check("b0_e6_press", 32'(btn_press), 32'h1);
    step();
    check("b0_e7_press", 32'(btn_press[0]), 32'd0);
    steps(30);
    check("b0_no_repeat", 32'(pulses[0]), 32'd1);
    btn_raw[0] = 1'b0;
    steps(5);
    check("b0_rel_e5", 32'(btn_n[0]), 32'd0);
    step();
    check("b0_rel_e6", 32'(btn_n[0]), 32'd1);
    check("b0_rel_no_pulse", 32'(pulses[0]), 32'd1);

    clear_log();
    for (int r = 0; r < 5; r++) begin
      btn_raw[1] = 1'b1;
      steps(3);
      btn_raw[1] = 1'b0;
      steps(3);
    end
    steps(6);
    check("b1_glitch_btn_n", 32'(n_min[1]), 32'd1);
    check("b1_glitch_pulses", 32'(pulses[1]), 32'd0);

    clear_log();
    btn_raw[3] = 1'b1;
    steps(60);
    check("b3_held_btn_n", 32'(btn_n[3]), 32'd0);
`ifdef BTN_AUTOREPEAT_EN
    exp_pe = '{6, 26, 34, 42, 50, 58};
`else
    exp_pe = '{6};
`endif
    check("b3_pulse_count", 32'(pe3.size()), 32'(exp_pe.size()));
    for (int i = 0; i < exp_pe.size() && i < pe3.size(); i++)
      check($sformatf("b3_pulse_edge%0d", i), 32'(pe3[i]), 32'(exp_pe[i]));
    btn_raw[3] = 1'b0;
    steps(5);
    check("b3_rel_e65", 32'(btn_n[3]), 32'd0);
    step();
    check("b3_rel_e66", 32'(btn_n[3]), 32'd1);
    check("b3_rel_press", 32'(btn_press[3]), 32'd0);
    steps(20);
    check("b3_after_rel_count", 32'(pe3.size()), 32'(exp_pe.size()));

    clear_log();
    btn_raw[3:2] = 2'b11;
    steps(5);
    check("b23_e5_press", 32'(btn_press), 32'h0);
    step();
    check("b23_same_cycle", 32'(btn_press), 32'hc);
    check("b23_btn_n", 32'(btn_n), 32'h3);
    steps(10);
    rst_n = 1'b0;
    step();
    check("b23_rst_btn_n", 32'(btn_n), 32'hf);
    check("b23_rst_press", 32'(btn_press), 32'h0);
    steps(2);
    check("b23_pulses_before_rel", 32'(pulses[2] + pulses[3]), 32'd2);
    rst_n = 1'b1;
    clear_log();
    steps(5);
    check("b23_post_e5_btn_n", 32'(btn_n), 32'hf);
    check("b23_post_e5_pulses", 32'(pulses[2] + pulses[3]), 32'd0);
    step();
    check("b23_post_e6_press", 32'(btn_press), 32'hc);
    check("b23_post_e6_btn_n", 32'(btn_n), 32'h3);
    step();
    check("b23_post_e7_press", 32'(btn_press), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
